fp32_to_int32_seq: RTL and testbench
====================================

Name: fp32_to_int32_seq

Overview:
- Multi-cycle converter from IEEE-754 single-precision to signed 32-bit two's-complement integer.
- It is the decode direction of the FP32 datapath: it unpacks a packed float into sign, exponent and significand, then aligns the significand into an integer.
- Uses a valid/ready handshake on input and output.
- Alignment uses an iterative shifter so area stays small, beside the FP32 adder in the arithmetic unit.

Parameters:
SHIFT_STEP, 1, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  reset; asynchronous, active-low
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept in_data
in_data  input  32  FP32 operand {s, exp[7:0], mant[22:0]}
out_valid  output  1  out_data and flags are valid
out_ready  input  1  consumer accepts the result
out_data  output  32  signed integer result
invalid  output  1  NaN, infinity or out-of-range input (result saturated)
inexact  output  1  result differs from the exact input value

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, out_data=0, invalid=0, inexact=0.
  - Takes effect immediately, including mid-operation; any in-flight conversion is discarded.
- FSM states: IDLE, CLASSIFY, SHIFT, ROUND, DONE.
- IDLE:
  - in_ready=1; all other states drive in_ready=0.
  - in_valid&in_ready at edge T latches in_data and moves to CLASSIFY.
- CLASSIFY (cycle T+1), unpacks fields and goes to DONE directly in these special cases:
  - exp=255, mant!=0 (NaN): out_data=0x80000000, invalid=1.
  - exp=255, mant=0 (infinity): +inf gives 0x7FFFFFFF, -inf gives 0x80000000, invalid=1.
  - exp>=158: out_data=0x80000000 and no flags only if s=1, exp=158, mant=0. Otherwise saturate by sign (as for infinity), invalid=1.
  - exp<=125, including zero and denormals: out_data=0; inexact=1 unless exp=0 and mant=0. -0.0 gives 0 with no flags.
- CLASSIFY, normal path (126<=exp<=157):
  - sig = {1, mant}, 24 bits.
  - exp<150: right shift count n=150-exp (1..24), with guard and sticky tracking.
  - exp>150: left shift count n=exp-150 (1..7) into a 32-bit magnitude.
  - exp=150: n=0.
  - Goes to SHIFT, or to ROUND if n=0.
- SHIFT:
  - Each cycle shifts by min(SHIFT_STEP, remaining) and decrements the counter.
  - On right shifts, the last bit shifted out becomes guard; every earlier shifted-out bit ORs into sticky.
  - Occupies k=ceil(n/SHIFT_STEP) cycles, then goes to ROUND.
- ROUND:
  - Round-to-nearest-even: increment if guard & (sticky | lsb).
  - inexact = guard | sticky.
  - Negate if s=1. Rounding overflow past 2^31-1 cannot occur for exp<=157.
  - Goes to DONE.
- DONE:
  - out_valid=1; out_data and flags stay stable until out_valid&out_ready.
  - Then goes to IDLE; in_ready returns to 1 in the following cycle (no same-cycle turnaround).
- Latency from the accept edge T:
  - Special cases: out_valid asserted in cycle T+2.
  - Normal path: out_valid asserted in cycle T+3+k.
- Boundary rules:
  - in_valid outside IDLE is ignored.
  - out_ready while out_valid=0 has no effect.
  - Flags are cleared on every accept.

Optional Feature:
FP2I_RMODE_EN
- Defined: adds input port rm[1:0], sampled with in_data on accept. Encodings: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
  - RTZ: never increments.
  - Toward +inf: increments magnitude if (guard|sticky)&~s.
  - Toward -inf: increments magnitude if (guard|sticky)&s.
  - Special-case handling is unchanged, except exp<=125 nonzero inputs round to +1 or -1 under the directed modes when the sign matches the rounding direction.
- Undefined: no rm port; always RNE.

Test Plan:
1. SHIFT_STEP=1, in_data=0x40490FDB (3.14159) accepted at T -> out_data=0x00000003, inexact=1, invalid=0, out_valid first high at T+25 (k=22).
2. Ties: 0x3F000000 (0.5) -> 0x00000000; 0x3FC00000 (1.5) -> 0x00000002; 0x40200000 (2.5) -> 0x00000002; all inexact=1. Also 0xBF800000 -> 0xFFFFFFFF with no flags, and 0x4B000000 -> 0x00800000 at T+3.
3. Range limits: 0xCF000000 -> 0x80000000, no flags, out_valid at T+2; 0x4F000000 -> 0x7FFFFFFF, invalid=1; 0x4EFFFFFF -> 0x7FFFFF80, no flags.
4. Specials: 0x7FC00000 -> 0x80000000, invalid=1; 0xFF800000 -> 0x80000000, invalid=1; 0x00000001 -> 0, inexact=1; 0x80000000 -> 0, no flags.
5. Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> out_data and flags stable, in_ready=0, second in_valid ignored. Release -> IDLE, next operand accepted one cycle later.
6. Drop rst_n during SHIFT of 0x40490FDB -> out_valid=0 and in_ready=1 immediately (async); after release, a fresh 0x3FC00000 converts to 0x00000002.

Source files
------------

// File: rtl/fp32_to_int32_seq.sv
// fp32_to_int32_seq: multi-cycle IEEE-754 single -> signed 32-bit integer converter.
// Valid/ready on both sides; the significand is aligned by an iterative shifter that
// moves SHIFT_STEP bits per cycle.
// Optional feature macro: FP2I_RMODE_EN adds rm[1:0] (00 RNE, 01 RTZ, 10 +inf, 11 -inf).
module fp32_to_int32_seq #(
  parameter int unsigned SHIFT_STEP = 1  // 1, 2, 4 or 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        invalid,
  output logic        inexact
`ifdef FP2I_RMODE_EN
  ,
  input  logic [1:0]  rm
`endif
);

  localparam logic [1:0] RmRtz = 2'b01;
  localparam logic [1:0] RmUp  = 2'b10;
  localparam logic [1:0] RmDn  = 2'b11;

  typedef enum logic [2:0] {StIdle, StClassify, StShift, StRound, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] op_q, op_d;
  logic [31:0] mag_q, mag_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic [31:0] out_data_q, out_data_d;
  logic        invalid_q, invalid_d;
  logic        inexact_q, inexact_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [1:0]  rm_q;

  // Field views of the latched operand.
  logic        sign;
  logic [7:0]  expo;
  logic [22:0] mant;
  assign sign = op_q[31];
  assign expo = op_q[30:23];
  assign mant = op_q[22:0];

  // Scratch for the shifter and rounder.
  logic [31:0] mag_v, mag_r;
  logic        guard_v, sticky_v, inc, tiny_up;
  logic [4:0]  cnt_v;

`ifdef FP2I_RMODE_EN
  logic [1:0] rm_d;
  // Rounding mode is captured together with the operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rm_q <= 2'b00;
    else        rm_q <= rm_d;
  end
  always_comb begin
    rm_d = rm_q;
    if (state_q == StIdle && in_valid) rm_d = rm;
  end
`else
  assign rm_q = 2'b00;
`endif

  // Round increment decision for the aligned magnitude.
  always_comb begin
    unique case (rm_q)
      RmRtz:   inc = 1'b0;
      RmUp:    inc = (guard_q | sticky_q) & ~sign;
      RmDn:    inc = (guard_q | sticky_q) & sign;
      default: inc = guard_q & (sticky_q | mag_q[0]);
    endcase
    mag_r   = mag_q + {31'd0, inc};
    // Directed modes push a tiny nonzero value away from zero when the sign agrees.
    tiny_up = ((rm_q == RmUp) && !sign) || ((rm_q == RmDn) && sign);
  end

  // Next-state logic for the FSM and datapath.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    mag_d       = mag_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    out_data_d  = out_data_q;
    invalid_d   = invalid_q;
    inexact_d   = inexact_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    mag_v       = mag_q;
    guard_v     = guard_q;
    sticky_v    = sticky_q;
    cnt_v       = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d       = in_data;
          invalid_d  = 1'b0;
          inexact_d  = 1'b0;
          in_ready_d = 1'b0;
          state_d    = StClassify;
        end
      end
      StClassify: begin
        if (expo == 8'd255) begin
          out_data_d  = (mant != 23'd0 || sign) ? 32'h8000_0000 : 32'h7FFF_FFFF;
          invalid_d   = 1'b1;
          state_d     = StDone;
          out_valid_d = 1'b1;
        end else if (expo >= 8'd158) begin
          if (sign && expo == 8'd158 && mant == 23'd0) begin
            out_data_d = 32'h8000_0000;
          end else begin
            out_data_d = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            invalid_d  = 1'b1;
          end
          state_d     = StDone;
          out_valid_d = 1'b1;
        end else if (expo <= 8'd125) begin
          inexact_d   = (expo != 8'd0) || (mant != 23'd0);
          out_data_d  = 32'd0;
          if (inexact_d && tiny_up) out_data_d = sign ? 32'hFFFF_FFFF : 32'd1;
          state_d     = StDone;
          out_valid_d = 1'b1;
        end else begin
          mag_d    = {8'd0, 1'b1, mant};
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          left_d   = (expo > 8'd150);
          cnt_d    = (expo > 8'd150) ? 5'(expo - 8'd150) : 5'(8'd150 - expo);
          state_d  = (expo == 8'd150) ? StRound : StShift;
        end
      end
      StShift: begin
        // Up to SHIFT_STEP single-bit steps, stopping when the count runs out.
        for (int unsigned i = 0; i < SHIFT_STEP; i++) begin
          if (cnt_v != 5'd0) begin
            if (left_q) begin
              mag_v = mag_v << 1;
            end else begin
              sticky_v = sticky_v | guard_v;
              guard_v  = mag_v[0];
              mag_v    = mag_v >> 1;
            end
            cnt_v = cnt_v - 5'd1;
          end
        end
        mag_d    = mag_v;
        guard_d  = guard_v;
        sticky_d = sticky_v;
        cnt_d    = cnt_v;
        if (cnt_v == 5'd0) state_d = StRound;
      end
      StRound: begin
        out_data_d  = sign ? (~mag_r + 32'd1) : mag_r;
        inexact_d   = guard_q | sticky_q;
        state_d     = StDone;
        out_valid_d = 1'b1;
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset discards any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= 32'd0;
      mag_q       <= 32'd0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= 5'd0;
      left_q      <= 1'b0;
      out_data_q  <= 32'd0;
      invalid_q   <= 1'b0;
      inexact_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      mag_q       <= mag_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      out_data_q  <= out_data_d;
      invalid_q   <= invalid_d;
      inexact_q   <= inexact_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign invalid   = invalid_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp32_to_int32_seq.sv
// Self-checking bench for fp32_to_int32_seq: directed cases, random operands against a
// real-arithmetic reference model, back-pressure and asynchronous reset mid-conversion.
module tb_fp32_to_int32_seq;

  localparam int unsigned STEP = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        invalid;
  logic        inexact;
  logic [1:0]  rm = 2'b00;

  int checks = 0;
  int errors = 0;

  fp32_to_int32_seq #(.SHIFT_STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .invalid   (invalid),
    .inexact   (inexact)
`ifdef FP2I_RMODE_EN
    ,
    .rm        (rm)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact value as a real, rounded per mode, range-checked.
  task automatic ref_model(input logic [31:0] d, input logic [1:0] mode,
                           output logic [31:0] o, output logic inv, output logic inx);
    int   e;
    real  x, fl, fr, r;
    longint fli, lv;
    e   = int'(d[30:23]);
    inv = 1'b0;
    inx = 1'b0;
    if (e == 255) begin
      inv = 1'b1;
      o   = (d[22:0] != 0 || d[31]) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return;
    end
    if (e == 0) x = real'(d[22:0]) * (2.0 ** (1 - 150));
    else        x = (real'(d[22:0]) + 8388608.0) * (2.0 ** (e - 150));
    if (d[31]) x = -x;
    fl  = $floor(x);
    fr  = x - fl;
    fli = longint'(fl);
    case (mode)
      2'b01:   r = (x >= 0.0) ? fl : $ceil(x);
      2'b10:   r = $ceil(x);
      2'b11:   r = fl;
      default: begin
        if (fr > 0.5)       r = fl + 1.0;
        else if (fr < 0.5)  r = fl;
        else                r = fli[0] ? fl + 1.0 : fl;
      end
    endcase
    if (r > 2147483647.0 || r < -2147483648.0) begin
      inv = 1'b1;
      o   = d[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return;
    end
    lv  = longint'(r);
    o   = lv[31:0];
    inx = (fr != 0.0);
  endtask

  function automatic int ref_lat(input logic [31:0] d);
    int e, n;
    e = int'(d[30:23]);
    if (e == 255 || e >= 158 || e <= 125) return 2;
    n = (e < 150) ? 150 - e : e - 150;
    return 3 + (n + int'(STEP) - 1) / int'(STEP);
  endfunction

  // Issue one operand, wait for its result, return result and latency, then consume it.
  task automatic convert(input logic [31:0] d, input logic [1:0] mode,
                         output logic [31:0] od, output logic inv, output logic inx,
                         output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    rm       = mode;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    od  = out_data;
    inv = invalid;
    inx = inexact;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [31:0] d, input logic [1:0] mode);
    logic [31:0] od, eo;
    logic inv, inx, einv, einx;
    int lat;
    convert(d, mode, od, inv, inx, lat);
    ref_model(d, mode, eo, einv, einx);
    check({tag, "_data"}, od, eo);
    check({tag, "_invalid"}, 32'(inv), 32'(einv));
    check({tag, "_inexact"}, 32'(inx), 32'(einx));
    check({tag, "_latency"}, 32'(lat), 32'(ref_lat(d)));
  endtask

  logic [31:0] directed [16] = '{
    32'h40490FDB, 32'h3F000000, 32'h3FC00000, 32'h40200000,
    32'hBF800000, 32'h4B000000, 32'hCF000000, 32'h4F000000,
    32'h4EFFFFFF, 32'h7FC00000, 32'hFF800000, 32'h00000001,
    32'h80000000, 32'h7F800000, 32'hC0200000, 32'hBFC00000
  };

  initial begin
    logic [31:0] d, od, held_d;
    logic inv, inx, held_inv, held_inx;
    logic [1:0] mode;
    int lat;

    // Reset state.
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_flags", {30'd0, invalid, inexact}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Explicit expectations from the worked examples, independent of the model.
    convert(32'h40490FDB, 2'b00, od, inv, inx, lat);
    check("pi_data", od, 32'h3);
    check("pi_flags", {30'd0, inv, inx}, 32'd1);
    check("pi_latency", 32'(lat), 32'd25);
    convert(32'h4EFFFFFF, 2'b00, od, inv, inx, lat);
    check("max_data", od, 32'h7FFFFF80);
    check("max_flags", {30'd0, inv, inx}, 32'd0);
    convert(32'hCF000000, 2'b00, od, inv, inx, lat);
    check("minint_data", od, 32'h8000_0000);
    check("minint_flags", {30'd0, inv, inx}, 32'd0);
    check("minint_latency", 32'(lat), 32'd2);

    foreach (directed[i]) run_check($sformatf("dir%0d", i), directed[i], 2'b00);

    // Random operands, biased toward the normal conversion range.
    for (int i = 0; i < 150; i++) begin
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d[30:23] = 8'($urandom_range(120, 160));
`ifdef FP2I_RMODE_EN
      mode = 2'($urandom_range(0, 3));
`else
      mode = 2'b00;
`endif
      run_check($sformatf("rnd%0d", i), d, mode);
    end

    // Back-pressure: result held, input ignored while DONE waits.
    in_valid = 1'b1;
    in_data  = 32'h3FC00000;
    rm       = 2'b00;
    @(posedge clk);
    @(negedge clk);
    in_data = 32'h4B000000;  // keeps in_valid high: must be ignored
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    held_d   = out_data;
    held_inv = invalid;
    held_inx = inexact;
    check("bp_data", held_d, 32'h2);
    check("bp_flags", {30'd0, held_inv, held_inx}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold_data", out_data, held_d);
      check("bp_hold_flags", {30'd0, invalid, inexact}, {30'd0, held_inv, held_inx});
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    convert(32'h40200000, 2'b00, od, inv, inx, lat);
    check("bp_next_data", od, 32'h2);

    // Asynchronous reset in the middle of SHIFT.
    in_valid = 1'b1;
    in_data  = 32'h40490FDB;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    convert(32'h3FC00000, 2'b00, od, inv, inx, lat);
    check("arst_fresh_data", od, 32'h2);
    check("arst_fresh_flags", {30'd0, inv, inx}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
